// File: rtl/inst_fetch_mem.sv
// rtl/inst_fetch_mem.sv - pipelined instruction memory for the fetch stage
// Valid/ready PC request in, instruction word out after LATENCY stages.
module inst_fetch_mem #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 128,
  parameter int                ADDR_W   = 32,
  parameter int                LATENCY  = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'hE000_0000,
  parameter int                PW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_inst,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              prog_we,
  input  logic [PW-1:0]     prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [31:0]       fetch_count
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              vld_q  [LATENCY];
  logic              vld_d  [LATENCY];
  logic [DATA_W-1:0] inst_q [LATENCY];
  logic [DATA_W-1:0] inst_d [LATENCY];
  logic [ADDR_W-1:0] addr_q [LATENCY];
  logic [ADDR_W-1:0] addr_d [LATENCY];
  logic              err_q  [LATENCY];
  logic              err_d  [LATENCY];
  logic [31:0]       fetch_count_q;
  logic [31:0]       fetch_count_d;

  logic              advance;
  logic              accept;
  logic [ADDR_W-1:0] word_addr;
  logic              req_err;
  logic [DATA_W-1:0] rd_inst;

  assign rsp_valid   = vld_q[LATENCY-1];
  assign rsp_inst    = inst_q[LATENCY-1];
  assign rsp_addr    = addr_q[LATENCY-1];
  assign rsp_err     = err_q[LATENCY-1];
  assign fetch_count = fetch_count_q;

  assign advance   = !vld_q[LATENCY-1] || rsp_ready;
  assign req_ready = advance && !flush && !rst;
  assign accept    = req_valid && req_ready;
  assign word_addr = req_addr >> 2;
  assign req_err   = (req_addr[1:0] != 2'b00) || (word_addr >= ADDR_W'(DEPTH));
  // Combinational read sees the pre-edge array, so a same-cycle write returns old data.
  assign rd_inst   = req_err ? NOP_WORD : mem[word_addr[PW-1:0]];

  always_comb begin
    for (int i = 0; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i];
      inst_d[i] = inst_q[i];
      addr_d[i] = addr_q[i];
      err_d[i]  = err_q[i];
    end
    if (flush) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_d[i] = 1'b0;
      end
    end else if (advance) begin
      vld_d[0]  = accept;
      inst_d[0] = rd_inst;
      addr_d[0] = req_addr;
      err_d[0]  = req_err;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i]  = vld_q[i-1];
        inst_d[i] = inst_q[i-1];
        addr_d[i] = addr_q[i-1];
        err_d[i]  = err_q[i-1];
      end
    end
  end

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (vld_q[LATENCY-1] && rsp_ready && !flush) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i]  <= 1'b0;
        inst_q[i] <= '0;
        addr_q[i] <= '0;
        err_q[i]  <= 1'b0;
      end
      fetch_count_q <= 32'd0;
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i]  <= vld_d[i];
        inst_q[i] <= inst_d[i];
        addr_q[i] <= addr_d[i];
        err_q[i]  <= err_d[i];
      end
      fetch_count_q <= fetch_count_d;
    end
  end

  // Program store survives reset and accepts writes even while the pipe is stalled.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

endmodule

// File: tb/tb_inst_fetch_mem.sv
// tb/tb_inst_fetch_mem.sv - bench for inst_fetch_mem at LATENCY 1 and 3
// Shared stimulus drives both instances; a scoreboard per instance checks responses.
module tb_inst_fetch_mem;

  localparam logic [31:0] NOP = 32'hE000_0000;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_ready;
  logic        prog_we;
  logic [6:0]  prog_addr;
  logic [31:0] prog_data;

  logic        rr [2];
  logic        rv [2];
  logic [31:0] ri [2];
  logic [31:0] ra [2];
  logic        re [2];
  logic [31:0] fc [2];

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_model [128];
  exp_t        sbq [2][$];
  logic [31:0] exp_cnt [2];

  always #5 clk = ~clk;

  inst_fetch_mem #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr[0]), .req_addr(req_addr),
    .flush(flush), .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_inst(ri[0]),
    .rsp_addr(ra[0]), .rsp_err(re[0]), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .fetch_count(fc[0])
  );

  inst_fetch_mem #(.LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr[1]), .req_addr(req_addr),
    .flush(flush), .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_inst(ri[1]),
    .rsp_addr(ra[1]), .rsp_err(re[1]), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .fetch_count(fc[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [31:0] a);
    exp_t e;
    e.addr = a;
    e.err  = (a[1:0] != 2'b00) || ((a >> 2) >= 32'd128);
    e.inst = e.err ? NOP : mem_model[a[8:2]];
    return e;
  endfunction

  // Sampled mid-cycle: inputs and state are stable until the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        sbq[d].delete();
        exp_cnt[d] = 32'd0;
      end
      check($sformatf("fetch_count_u%0d", d), fc[d], exp_cnt[d]);
      if (!rst) begin
        if (rv[d] && rsp_ready) begin
          if (sbq[d].size() == 0) begin
            checks++;
            failures++;
            $error("FAIL unexpected_rsp_u%0d observed=addr %h expected=no response", d, ra[d]);
          end else begin
            e = sbq[d].pop_front();
            check($sformatf("rsp_inst_u%0d", d), ri[d], e.inst);
            check($sformatf("rsp_addr_u%0d", d), ra[d], e.addr);
            check($sformatf("rsp_err_u%0d", d), {31'd0, re[d]}, {31'd0, e.err});
          end
          if (!flush) exp_cnt[d] = exp_cnt[d] + 32'd1;
        end
        if (flush) sbq[d].delete();
        else if (req_valid && rr[d]) sbq[d].push_back(model(req_addr));
      end
    end
    if (prog_we) mem_model[prog_addr] = prog_data;
  end

  task automatic prog(input logic [6:0] a, input logic [31:0] v);
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = v;
    tick();
    prog_we = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = 32'd0;
    flush = 1'b0;
    rsp_ready = 1'b0;
    prog_we = 1'b0;
    prog_addr = 7'd0;
    prog_data = 32'd0;

    repeat (2) tick();
    for (int d = 0; d < 2; d++) begin
      check("reset_rsp_valid", {31'd0, rv[d]}, 32'd0);
      check("reset_rsp_inst", ri[d], 32'd0);
      check("reset_rsp_addr", ra[d], 32'd0);
      check("reset_req_ready", {31'd0, rr[d]}, 32'd0);
    end
    rst = 1'b0;

    prog(7'd0, 32'hE3A0_0014);
    prog(7'd1, 32'hE3A0_1A01);
    prog(7'd2, 32'hE3A0_2103);
    prog(7'd3, 32'hE092_3002);
    prog(7'd16, 32'hEAFF_FFFE);

    // Stream 0,4,8,12 and watch first-response latency of each instance.
    req_valid = 1'b1; req_addr = 32'd0; rsp_ready = 1'b1;
    #1;
    check("req_ready_u1", {31'd0, rr[0]}, 32'd1);
    check("req_ready_u3", {31'd0, rr[1]}, 32'd1);
    tick(); req_addr = 32'd4; #1;
    check("lat1_valid_u1", {31'd0, rv[0]}, 32'd1);
    check("lat1_valid_u3", {31'd0, rv[1]}, 32'd0);
    tick(); req_addr = 32'd8; #1;
    check("lat2_valid_u3", {31'd0, rv[1]}, 32'd0);
    tick(); req_addr = 32'd12; #1;
    check("lat3_valid_u3", {31'd0, rv[1]}, 32'd1);
    check("lat3_addr_u3", ra[1], 32'd0);
    tick(); req_valid = 1'b0; #1;
    check("nobubble_u3", {31'd0, rv[1]}, 32'd1);
    repeat (5) tick();
    check("count_stream_u1", fc[0], 32'd4);
    check("count_stream_u3", fc[1], 32'd4);

    // Back-pressure while word 1 sits at the u3 output.
    req_valid = 1'b1; req_addr = 32'd0;
    tick(); req_addr = 32'd4;
    tick(); req_addr = 32'd8;
    tick(); req_addr = 32'd12;
    tick(); req_valid = 1'b0; rsp_ready = 1'b0; #1;
    check("stall0_inst_u3", ri[1], 32'hE3A0_1A01);
    check("stall0_ready_u3", {31'd0, rr[1]}, 32'd0);
    check("stall0_ready_u1", {31'd0, rr[0]}, 32'd0);
    tick();
    check("stall1_inst_u3", ri[1], 32'hE3A0_1A01);
    check("stall1_valid_u3", {31'd0, rv[1]}, 32'd1);
    check("stall1_ready_u3", {31'd0, rr[1]}, 32'd0);
    tick();
    check("stall2_inst_u3", ri[1], 32'hE3A0_1A01);
    rsp_ready = 1'b1;
    repeat (5) tick();
    check("count_bp_u1", fc[0], 32'd8);
    check("count_bp_u3", fc[1], 32'd8);
    check("sb_empty_bp_u3", sbq[1].size(), 32'd0);

    // Error paths: misaligned, one past the end, then a clean fetch.
    req_valid = 1'b1; req_addr = 32'd6;
    tick(); req_addr = 32'd512; #1;
    check("err_misalign_inst", ri[0], NOP);
    check("err_misalign_flag", {31'd0, re[0]}, 32'd1);
    tick(); req_addr = 32'd4; #1;
    check("err_range_inst", ri[0], NOP);
    check("err_range_flag", {31'd0, re[0]}, 32'd1);
    tick(); req_valid = 1'b0; #1;
    check("ok_flag", {31'd0, re[0]}, 32'd0);
    check("ok_inst", ri[0], 32'hE3A0_1A01);
    repeat (5) tick();

    // Flush with three fetches in flight on u3.
    req_valid = 1'b1; req_addr = 32'd0;
    tick(); req_addr = 32'd4;
    tick(); req_addr = 32'd8;
    tick(); req_valid = 1'b0; flush = 1'b1; #1;
    check("flush_ready_u3", {31'd0, rr[1]}, 32'd0);
    tick(); flush = 1'b0; #1;
    check("flush_valid_u1", {31'd0, rv[0]}, 32'd0);
    check("flush_valid_u3", {31'd0, rv[1]}, 32'd0);
    check("flush_count_u1", fc[0], 32'd13);
    check("flush_count_u3", fc[1], 32'd11);
    req_valid = 1'b1; req_addr = 32'h40;
    tick(); req_valid = 1'b0;
    n = 0;
    while (rv[1] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("after_flush_valid_u3", {31'd0, rv[1]}, 32'd1);
    check("after_flush_addr_u3", ra[1], 32'h40);
    check("after_flush_inst_u3", ri[1], 32'hEAFF_FFFE);
    repeat (4) tick();

    // Write/read collision on word 2.
    req_valid = 1'b1; req_addr = 32'd8;
    prog_we = 1'b1; prog_addr = 7'd2; prog_data = 32'hDEAD_BEEF;
    tick(); prog_we = 1'b0; #1;
    check("collide_old_u1", ri[0], 32'hE3A0_2103);
    tick(); req_valid = 1'b0; #1;
    check("collide_new_u1", ri[0], 32'hDEAD_BEEF);
    repeat (5) tick();

    // Asynchronous reset mid-stream.
    req_valid = 1'b1; req_addr = 32'd0;
    tick(); req_addr = 32'd4;
    tick(); req_addr = 32'd8;
    rst = 1'b1; #1;
    for (int d = 0; d < 2; d++) begin
      check("arst_rsp_valid", {31'd0, rv[d]}, 32'd0);
      check("arst_rsp_inst", ri[d], 32'd0);
      check("arst_rsp_addr", ra[d], 32'd0);
      check("arst_rsp_err", {31'd0, re[d]}, 32'd0);
      check("arst_count", fc[d], 32'd0);
      check("arst_req_ready", {31'd0, rr[d]}, 32'd0);
    end
    req_valid = 1'b0;
    tick(); rst = 1'b0;
    req_valid = 1'b1; req_addr = 32'd12;
    tick(); req_addr = 32'd8; #1;
    check("post_rst_inst_u1", ri[0], 32'hE092_3002);
    tick(); req_valid = 1'b0; #1;
    check("post_rst_retained_u1", ri[0], 32'hDEAD_BEEF);
    repeat (5) tick();
    check("post_rst_count_u1", fc[0], 32'd2);
    check("post_rst_count_u3", fc[1], 32'd2);
    check("sb_empty_end_u1", sbq[0].size(), 32'd0);
    check("sb_empty_end_u3", sbq[1].size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_mem.md
# inst_fetch_mem

Parametrised, pipelined instruction memory for the ARM pipeline's fetch stage. Takes a byte-addressed PC request over a valid/ready handshake, returns the instruction word after a configurable number of read stages, and supports back-pressure, a branch flush and a runtime programming port. Out-of-range or misaligned fetches return a NOP and an error flag. It sits between the PC register / IF stage and the IF/ID pipeline register.

## Interface
- DATA_W, 32, instruction width in bits
- DEPTH, 128, number of instruction words
- ADDR_W, 32, request byte-address width
- LATENCY, 1, read pipeline stages; legal 1..4
- NOP_WORD, 32'hE000_0000, word returned on error fetches (AL-condition AND R0,R0,R0)
- PW = clog2(DEPTH), derived width of the word index

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  fetch request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_addr  in  ADDR_W  byte address (PC)
- flush  in  1  discard all in-flight fetches (branch taken)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_inst  out  DATA_W  instruction word
- rsp_addr  out  ADDR_W  byte address that produced rsp_inst
- rsp_err  out  1  misaligned (req_addr[1:0]≠0) or out-of-range (req_addr>>2 ≥ DEPTH)
- prog_we  in  1  program-port write enable
- prog_addr  in  PW  word index to write
- prog_data  in  DATA_W  word to write
- fetch_count  out  32  count of completed responses

## Operation
- Storage: DEPTH×DATA_W array; written at the rising edge when prog_we=1; contents unaffected by rst.
- Pipeline: LATENCY stages, each holding valid, inst, addr, err. Stage 1 is loaded on acceptance (req_valid && req_ready); the array is read at that edge.
- advance = !rsp_valid || rsp_ready (rsp_* comes from the last stage). All stages shift together when advance=1 and hold when advance=0. Bubbles propagate as valid=0.
- req_ready = advance && !flush && !rst.
- Error fetch: inst=NOP_WORD, err=1, addr=req_addr; no array access.
- Write/read collision: a prog write to the word being fetched in the same cycle returns the OLD contents. The new contents are visible from the next acceptance.
- flush=1 at an edge clears every stage valid bit (including the output); no request is accepted that cycle. flush has priority over everything except rst.
- fetch_count increments on each rsp_valid && rsp_ready edge and wraps 2^32−1 → 0. A response discarded by flush is not counted.
- Reset: all stage valids=0, rsp_valid=0, rsp_inst=0, rsp_addr=0, rsp_err=0, fetch_count=0, req_ready=0 while rst is high. Reset asserted mid-stream drops every in-flight fetch immediately (asynchronous), without waiting for a clock edge.

## Timing
- Latency: a request accepted at edge k gives rsp_valid=1 after edge k+LATENCY−1, with no stall.
- Throughput: one fetch per cycle while rsp_ready=1.
- Back-pressure: with rsp_ready=0 and rsp_valid=1, rsp_* stays stable and req_ready is 0 the same cycle (combinational).
- Simultaneous events:
  - rsp_ready=1 with flush=1: the response is consumed but not counted.
  - prog_we with a stall: the write still happens.
- The first edge after rst deasserts may accept a request.

## Test plan
- Preload words 0..3 = 0xE3A00014, 0xE3A01A01, 0xE3A02103, 0xE0923002; set LATENCY=1; stream addresses 0,4,8,12 with rsp_ready=1 → four back-to-back responses one cycle after each acceptance with matching rsp_addr; fetch_count=4.
- LATENCY=3: same stream → first rsp_valid after the 3rd edge; order preserved; no bubbles.
- Back-pressure: drop rsp_ready for 2 cycles mid-stream → rsp_inst holds 0xE3A01A01, req_ready=0, no loss or duplication after release.
- Error paths:
  - addr=6 → NOP_WORD, rsp_err=1.
  - addr=4×DEPTH → NOP_WORD, rsp_err=1.
  - addr=4 → rsp_err=0.
- flush with 3 fetches in flight (LATENCY=3) → rsp_valid=0 next cycle; the fetch of 0x40 issued afterwards is the next response; fetch_count unchanged by the flush.
- Collision and reset:
  - prog_we to word 2 with 0xDEADBEEF in the cycle addr=8 is accepted → 0xE3A02103 returned, next fetch of 8 → 0xDEADBEEF.
  - rst pulsed mid-stream → all outputs at reset values before the next edge; array contents retained.
